// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for one pipeline-stage boundary.
// The upstream producer pushes on the in_* side and the downstream consumer
// pops on the out_* side. The stage itself connects through the slave modport.
// The driving environment connects through the master modport.
interface pipe_stage_skid_if #(
  parameter int CTRL_W = 2,
  parameter int DATA_W = 69
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;

  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  // Environment side: produces entries and consumes the head.
  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  // Stage side: accepts entries and presents the head.
  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Generic inter-stage pipeline register with valid/ready flow control.
// SKID=1 builds a main slot plus a skid slot, so in_ready can come straight
// from a flop and is cut off from out_ready.
// SKID=0 builds a single slot whose in_ready depends combinationally on
// out_ready.
// Control bits and payload are forced to zero whenever the head slot is
// empty. This means a write-enable can never leak out of a bubble or out of
// a flushed entry.
module pipe_stage_skid #(
  parameter int CTRL_W = 2,
  parameter int DATA_W = 69,
  parameter bit SKID   = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  pipe_stage_skid_if.slave    bus,
  output logic [1:0]          occupancy
);

  // Head slot, shared by both build variants.
  logic              main_valid_reg;
  logic [CTRL_W-1:0] main_ctrl_reg;
  logic [DATA_W-1:0] main_data_reg;

  logic              push;
  logic              pop;

  // Handshakes complete only when both sides agree in the same cycle.
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = main_valid_reg & bus.out_ready;

  generate
    if (SKID) begin : g_skid
      logic              skid_valid_reg;
      logic [CTRL_W-1:0] skid_ctrl_reg;
      logic [DATA_W-1:0] skid_data_reg;
      logic              in_ready_reg;
      logic              skid_valid_next;

      // The skid slot fills only when the head is busy and does not drain
      // this cycle. Any pop empties the skid slot, because its entry moves
      // into the head.
      always_comb begin
        skid_valid_next = skid_valid_reg;
        if (flush) begin
          skid_valid_next = 1'b0;
        end else if (pop) begin
          skid_valid_next = 1'b0;
        end else if (push && main_valid_reg) begin
          skid_valid_next = 1'b1;
        end
      end

      // Head and skid slot update; in_ready is registered from the next
      // skid state.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          main_valid_reg <= 1'b0;
          main_ctrl_reg  <= '0;
          main_data_reg  <= '0;
          skid_valid_reg <= 1'b0;
          skid_ctrl_reg  <= '0;
          skid_data_reg  <= '0;
          in_ready_reg   <= 1'b0;
        end else begin
          skid_valid_reg <= skid_valid_next;
          in_ready_reg   <= !skid_valid_next;
          if (flush) begin
            main_valid_reg <= 1'b0;
          end else begin
            // The head refills whenever it is empty or being consumed.
            // The older skid entry always wins over a fresh push, which
            // keeps the stream in order.
            if (!main_valid_reg || pop) begin
              if (skid_valid_reg) begin
                main_valid_reg <= 1'b1;
                main_ctrl_reg  <= skid_ctrl_reg;
                main_data_reg  <= skid_data_reg;
              end else if (push) begin
                main_valid_reg <= 1'b1;
                main_ctrl_reg  <= bus.in_ctrl;
                main_data_reg  <= bus.in_data;
              end else begin
                main_valid_reg <= 1'b0;
              end
            end
            // A push that cannot reach the head is parked in the skid slot.
            if (push && main_valid_reg && !pop) begin
              skid_ctrl_reg <= bus.in_ctrl;
              skid_data_reg <= bus.in_data;
            end
          end
        end
      end

      assign bus.in_ready = in_ready_reg;
      assign occupancy    = {1'b0, main_valid_reg} + {1'b0, skid_valid_reg};
    end else begin : g_single
      // Space is available when the slot is empty or is being drained this
      // cycle. Reset holds the stage closed.
      assign bus.in_ready = !reset && (!main_valid_reg || bus.out_ready);

      // Single-slot update: a push, including push-with-pop, overwrites the
      // slot. A lone pop empties it.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          main_valid_reg <= 1'b0;
          main_ctrl_reg  <= '0;
          main_data_reg  <= '0;
        end else if (flush) begin
          main_valid_reg <= 1'b0;
        end else if (push) begin
          main_valid_reg <= 1'b1;
          main_ctrl_reg  <= bus.in_ctrl;
          main_data_reg  <= bus.in_data;
        end else if (pop) begin
          main_valid_reg <= 1'b0;
        end
      end

      assign occupancy = {1'b0, main_valid_reg};
    end
  endgenerate

  // Bubble-safe outputs: every control and payload bit is masked by the
  // head valid.
  logic [CTRL_W-1:0] ctrl_gated;
  logic [DATA_W-1:0] data_gated;

  genvar gi;
  generate
    for (gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_gate
      assign ctrl_gated[gi] = main_ctrl_reg[gi] & main_valid_reg;
    end
    for (gi = 0; gi < DATA_W; gi++) begin : g_data_gate
      assign data_gated[gi] = main_data_reg[gi] & main_valid_reg;
    end
  endgenerate

  assign bus.out_valid = main_valid_reg;
  assign bus.out_ctrl  = ctrl_gated;
  assign bus.out_data  = data_gated;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid.
// One instance is built with the skid buffer and one without.
// A FIFO scoreboard records every accepted entry and checks each consumed
// head against that record. Scenario tasks check latency, occupancy,
// ready behaviour and reset/flush effects inline.
module tb_pipe_stage_skid;
  localparam int CW = 2;
  localparam int DW = 69;

  logic          clk;
  logic          reset;
  logic          flush_a;
  logic          flush_b;
  logic [1:0]    occ_a;
  logic [1:0]    occ_b;

  int checks;
  int failures;

  logic [CW+DW-1:0] q_a[$];
  logic [CW+DW-1:0] q_b[$];

  pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) bus_a ();
  pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) bus_b ();

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush_a),
    .bus       (bus_a),
    .occupancy (occ_a)
  );

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush_b),
    .bus       (bus_b),
    .occupancy (occ_b)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: on each falling edge, compare the consumed heads and then
  // record the accepted pushes.
  always @(negedge clk) begin
    logic [CW+DW-1:0] exp_v;
    if (reset) begin
      q_a.delete();
      q_b.delete();
    end else begin
      if (bus_a.out_valid) begin
        if (bus_a.out_ready) begin
          checks++;
          if (q_a.size() == 0) begin
            failures++;
            $display("FAIL sb_a_unexpected got=%h required=none", {bus_a.out_ctrl, bus_a.out_data});
          end else begin
            exp_v = q_a.pop_front();
            if ({bus_a.out_ctrl, bus_a.out_data} !== exp_v) begin
              failures++;
              $display("FAIL sb_a_order got=%h required=%h", {bus_a.out_ctrl, bus_a.out_data}, exp_v);
            end
          end
        end
      end else begin
        checks++;
        if ({bus_a.out_ctrl, bus_a.out_data} !== '0) begin
          failures++;
          $display("FAIL sb_a_bubble got=%h required=0", {bus_a.out_ctrl, bus_a.out_data});
        end
      end
      if (flush_a) q_a.delete();
      else if (bus_a.in_valid && bus_a.in_ready) q_a.push_back({bus_a.in_ctrl, bus_a.in_data});

      if (bus_b.out_valid) begin
        if (bus_b.out_ready) begin
          checks++;
          if (q_b.size() == 0) begin
            failures++;
            $display("FAIL sb_b_unexpected got=%h required=none", {bus_b.out_ctrl, bus_b.out_data});
          end else begin
            exp_v = q_b.pop_front();
            if ({bus_b.out_ctrl, bus_b.out_data} !== exp_v) begin
              failures++;
              $display("FAIL sb_b_order got=%h required=%h", {bus_b.out_ctrl, bus_b.out_data}, exp_v);
            end
          end
        end
      end else begin
        checks++;
        if ({bus_b.out_ctrl, bus_b.out_data} !== '0) begin
          failures++;
          $display("FAIL sb_b_bubble got=%h required=0", {bus_b.out_ctrl, bus_b.out_data});
        end
      end
      if (flush_b) q_b.delete();
      else if (bus_b.in_valid && bus_b.in_ready) q_b.push_back({bus_b.in_ctrl, bus_b.in_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bus_a.out_valid, bus_a.out_ctrl, occ_a, bus_a.in_ready} !== '0 || bus_a.out_data !== '0) begin
      failures++;
      $display("FAIL reset_a got valid=%b ctrl=%b occ=%0d rdy=%b", bus_a.out_valid, bus_a.out_ctrl, occ_a, bus_a.in_ready);
    end
    checks++;
    if ({bus_b.out_valid, occ_b, bus_b.in_ready} !== '0) begin
      failures++;
      $display("FAIL reset_b got valid=%b occ=%0d rdy=%b required 0", bus_b.out_valid, occ_b, bus_b.in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (bus_b.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_b_ready got=%b required=1", bus_b.in_ready);
    end
    tick();
    checks++;
    if (bus_a.in_ready !== 1'b1 || occ_a !== 2'd0) begin
      failures++;
      $display("FAIL reset_release_a got rdy=%b occ=%0d required rdy=1 occ=0", bus_a.in_ready, occ_a);
    end
    $display("test_reset done");
  endtask

  task automatic test_streaming();
    bus_a.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_ctrl  = CW'(i);
      bus_a.in_data  = DW'(i);
      tick();
      checks++;
      if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== DW'(i) || occ_a > 2'd1 || bus_a.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL stream_%0d got valid=%b data=%0h occ=%0d rdy=%b required data=%0h", i, bus_a.out_valid, bus_a.out_data, occ_a, bus_a.in_ready, i);
      end
    end
    bus_a.in_valid = 1'b0;
    tick();
    checks++;
    if (bus_a.out_valid !== 1'b0 || occ_a !== 2'd0) begin
      failures++;
      $display("FAIL stream_drain got valid=%b occ=%0d required 0", bus_a.out_valid, occ_a);
    end
    $display("test_streaming done");
  endtask

  task automatic test_backpressure();
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.in_ctrl = 2'b01; bus_a.in_data = DW'(8'hA1);
    tick();
    checks++;
    if (occ_a !== 2'd1 || bus_a.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_first got occ=%0d rdy=%b required occ=1 rdy=1", occ_a, bus_a.in_ready);
    end
    bus_a.in_ctrl = 2'b10; bus_a.in_data = DW'(8'hB2);
    tick();
    checks++;
    if (occ_a !== 2'd2 || bus_a.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_full got occ=%0d rdy=%b required occ=2 rdy=0", occ_a, bus_a.in_ready);
    end
    bus_a.in_ctrl = 2'b11; bus_a.in_data = DW'(8'hC3);
    tick();
    tick();
    checks++;
    if (occ_a !== 2'd2 || bus_a.in_ready !== 1'b0 || bus_a.out_data !== DW'(8'hA1)) begin
      failures++;
      $display("FAIL bp_hold got occ=%0d rdy=%b data=%0h required occ=2 rdy=0 data=a1", occ_a, bus_a.in_ready, bus_a.out_data);
    end
    bus_a.out_ready = 1'b1;
    tick();
    checks++;
    if (bus_a.out_data !== DW'(8'hB2) || occ_a !== 2'd1 || bus_a.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release1 got data=%0h occ=%0d rdy=%b required data=b2 occ=1 rdy=1", bus_a.out_data, occ_a, bus_a.in_ready);
    end
    tick();
    checks++;
    if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== DW'(8'hC3) || bus_a.out_ctrl !== 2'b11) begin
      failures++;
      $display("FAIL bp_release2 got valid=%b data=%0h required valid=1 data=c3", bus_a.out_valid, bus_a.out_data);
    end
    bus_a.in_valid = 1'b0;
    tick();
    checks++;
    if (bus_a.out_valid !== 1'b0 || occ_a !== 2'd0) begin
      failures++;
      $display("FAIL bp_drain got valid=%b occ=%0d required 0", bus_a.out_valid, occ_a);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_flush();
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.in_ctrl = 2'b11; bus_a.in_data = DW'(8'h1F);
    tick();
    flush_a = 1'b1;
    bus_a.in_ctrl = 2'b11; bus_a.in_data = DW'(8'h77);
    tick();
    flush_a = 1'b0;
    bus_a.in_valid = 1'b0;
    checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.out_ctrl !== 2'b00 || bus_a.out_data !== '0 || occ_a !== 2'd0) begin
      failures++;
      $display("FAIL flush_kill got valid=%b ctrl=%b data=%0h occ=%0d required all 0", bus_a.out_valid, bus_a.out_ctrl, bus_a.out_data, occ_a);
    end
    bus_a.out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_no_ghost got valid=%b rdy=%b required valid=0 rdy=1", bus_a.out_valid, bus_a.in_ready);
    end
    $display("test_flush done");
  endtask

  task automatic test_full_push_pop();
    logic [7:0] src[3];
    logic [7:0] head_exp[3];
    int k;
    logic acc;
    src[0] = 8'h33; src[1] = 8'h34; src[2] = 8'h35;
    head_exp[0] = 8'h32; head_exp[1] = 8'h33; head_exp[2] = 8'h34;
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.in_ctrl = 2'b01; bus_a.in_data = DW'(8'h31);
    tick();
    bus_a.in_ctrl = 2'b10; bus_a.in_data = DW'(8'h32);
    tick();
    checks++;
    if (occ_a !== 2'd2 || bus_a.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_setup got occ=%0d rdy=%b required occ=2 rdy=0", occ_a, bus_a.in_ready);
    end
    bus_a.out_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 3; c++) begin
      bus_a.in_ctrl = 2'b00;
      bus_a.in_data = DW'(src[k]);
      acc = bus_a.in_ready;
      tick();
      if (acc) k++;
      checks++;
      if (occ_a !== 2'd1 || bus_a.in_ready !== 1'b1 || bus_a.out_data !== DW'(head_exp[c])) begin
        failures++;
        $display("FAIL full_pp_%0d got occ=%0d rdy=%b data=%0h required occ=1 rdy=1 data=%0h", c, occ_a, bus_a.in_ready, bus_a.out_data, head_exp[c]);
      end
    end
    checks++;
    if (k != 2) begin
      failures++;
      $display("FAIL full_pp_accepted got=%0d required=2", k);
    end
    bus_a.in_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (occ_a !== 2'd0) begin
      failures++;
      $display("FAIL full_pp_drain got occ=%0d required=0", occ_a);
    end
    $display("test_full_push_pop done");
  endtask

  task automatic test_async_reset();
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.in_ctrl = 2'b11; bus_a.in_data = DW'(8'h41);
    tick();
    bus_a.in_data = DW'(8'h42);
    tick();
    bus_a.in_valid = 1'b0;
    checks++;
    if (occ_a !== 2'd2) begin
      failures++;
      $display("FAIL areset_setup got occ=%0d required=2", occ_a);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.out_ctrl !== 2'b00 || occ_a !== 2'd0 || bus_a.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL areset_immediate got valid=%b ctrl=%b occ=%0d rdy=%b required all 0", bus_a.out_valid, bus_a.out_ctrl, occ_a, bus_a.in_ready);
    end
    tick();
    reset = 1'b0;
    tick();
    bus_a.out_ready = 1'b1;
    bus_a.in_valid  = 1'b1;
    bus_a.in_ctrl = 2'b10; bus_a.in_data = DW'(8'h5A);
    tick();
    bus_a.in_valid = 1'b0;
    checks++;
    if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== DW'(8'h5A)) begin
      failures++;
      $display("FAIL areset_first got valid=%b data=%0h required valid=1 data=5a", bus_a.out_valid, bus_a.out_data);
    end
    tick();
    $display("test_async_reset done");
  endtask

  task automatic test_skid0();
    bus_b.out_ready = 1'b0;
    bus_b.in_valid  = 1'b1;
    bus_b.in_ctrl = 2'b01; bus_b.in_data = DW'(8'h11);
    tick();
    bus_b.in_valid = 1'b0;
    #1;
    checks++;
    if (bus_b.in_ready !== 1'b0 || occ_b !== 2'd1) begin
      failures++;
      $display("FAIL skid0_stall got rdy=%b occ=%0d required rdy=0 occ=1", bus_b.in_ready, occ_b);
    end
    bus_b.out_ready = 1'b1;
    bus_b.in_valid  = 1'b1;
    bus_b.in_ctrl = 2'b10; bus_b.in_data = DW'(8'h22);
    #1;
    checks++;
    if (bus_b.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL skid0_comb_ready got=%b required=1", bus_b.in_ready);
    end
    tick();
    checks++;
    if (bus_b.out_valid !== 1'b1 || bus_b.out_data !== DW'(8'h22) || occ_b !== 2'd1) begin
      failures++;
      $display("FAIL skid0_replace got valid=%b data=%0h occ=%0d required valid=1 data=22 occ=1", bus_b.out_valid, bus_b.out_data, occ_b);
    end
    for (int i = 0; i < 3; i++) begin
      bus_b.in_ctrl = CW'(i);
      bus_b.in_data = DW'(8'h60 + i);
      tick();
      checks++;
      if (bus_b.out_data !== DW'(8'h60 + i) || occ_b !== 2'd1) begin
        failures++;
        $display("FAIL skid0_stream_%0d got data=%0h occ=%0d required data=%0h occ=1", i, bus_b.out_data, occ_b, 8'h60 + i);
      end
    end
    bus_b.in_valid = 1'b0;
    tick();
    checks++;
    if (bus_b.out_valid !== 1'b0 || occ_b !== 2'd0) begin
      failures++;
      $display("FAIL skid0_drain got valid=%b occ=%0d required 0", bus_b.out_valid, occ_b);
    end
    $display("test_skid0 done");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    flush_a  = 1'b0;
    flush_b  = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_ctrl = '0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_ctrl = '0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;

    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_full_push_pop();
    test_async_reset();
    test_skid0();

    tick();
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got a=%0d b=%0d required 0", q_a.size(), q_b.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
